// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display multiplexer: active-low hex
// glyphs, the all-off code and the digit-index width helper.
package seg_pkg;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // {g,f,e,d,c,b,a}, active-low; element 15 (F) is leftmost
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_display_mux_hex7seg.sv
// Combinational hex digit to active-low seven-segment pattern decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    always_comb seg_c = HEX_SEG[hex];

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment display driver with frame-synchronous data
// and brightness update, PWM dimming and per-slot anti-ghost blanking.
// Optional leading-zero suppression: define SEG_LEADING_ZERO_BLANK_EN.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned PWM_BITS     = 2,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                    Clk_100M,
    input  logic                    Reset_n,
    input  logic                    Enable,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Digits,
    input  logic [NUM_DIGITS-1:0]   Dp,
    input  logic [PWM_BITS-1:0]     Brightness,
    output logic [NUM_DIGITS-1:0]   SegmentDrivers,
    output logic [7:0]              SevenSegment,
    output logic                    Frame_Start
);

    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]    SLOT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_FULL = '1;

    logic [CNT_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] pend_digits, disp_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
    logic [PWM_BITS-1:0]     bright_q;

    logic                  slot_wrap_c, frame_wrap_c, lit_c, blank_c, cur_dp_c;
    logic [3:0]            cur_hex_c;
    logic [NUM_DIGITS-1:0] anode_c;
    logic [6:0]            hex_seg_c, seg_body_c;

    assign slot_wrap_c  = (slot_cnt == SLOT_LAST);
    assign frame_wrap_c = slot_wrap_c && (digit_idx == IDX_LAST);

    // Slot, digit and PWM counters run regardless of Enable
    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            slot_cnt <= slot_wrap_c ? '0 : slot_cnt + CNT_W'(1);
            if (slot_wrap_c)
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end
    end

    // The last clock of a frame commits pending data (or a coincident Load) and brightness
    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            disp_digits <= '0;
            disp_dp     <= '0;
            bright_q    <= '0;
        end else begin
            if (Load) begin
                pend_digits <= Digits;
                pend_dp     <= Dp;
            end
            if (frame_wrap_c) begin
                disp_digits <= Load ? Digits : pend_digits;
                disp_dp     <= Load ? Dp     : pend_dp;
                bright_q    <= Brightness;
            end
        end
    end

    always_comb begin
        cur_hex_c = 4'h0;
        cur_dp_c  = 1'b0;
        anode_c   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_hex_c  = disp_digits[4*i +: 4];
                cur_dp_c   = disp_dp[i];
                anode_c[i] = 1'b0;
            end
        end
    end

    hex7seg u_hex7seg (
        .hex   (cur_hex_c),
        .seg_c (hex_seg_c)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic lz_blank_c;

    // A digit is suppressed while it and every more significant digit are zero
    always_comb begin : lz_scan
        logic zero_run;
        zero_run   = 1'b1;
        lz_blank_c = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp_digits[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i))
                lz_blank_c = zero_run;
        end
    end

    assign seg_body_c = lz_blank_c ? SEG_BLANK : hex_seg_c;
`else
    assign seg_body_c = hex_seg_c;
`endif

    assign lit_c   = (bright_q == BRIGHT_FULL) || (pwm_cnt < bright_q);
    assign blank_c = 32'(slot_cnt) < BLANK_CYCLES;

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            SegmentDrivers <= '1;
            SevenSegment   <= SEG_OFF;
            Frame_Start    <= 1'b0;
        end else begin
            Frame_Start <= frame_wrap_c;
            if (Enable && !blank_c && lit_c) begin
                SegmentDrivers <= anode_c;
                SevenSegment   <= {~cur_dp_c, seg_body_c};
            end else begin
                SegmentDrivers <= '1;
                SevenSegment   <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Randomised bench for seg_display_mux against a cycle-count reference model.
module tb_seg_display_mux;

    localparam int unsigned ND    = 4;
    localparam int unsigned RD    = 8;
    localparam int unsigned PB    = 2;
    localparam int unsigned BC    = 2;
    localparam int unsigned FRAME = RD * ND;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [1:0]  bright;
    logic [3:0]  seg_drv;
    logic [7:0]  seven_seg;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    // Model: state after n edges is slot=n%RD, digit=(n/RD)%ND, pwm=n%4
    int unsigned n;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pend_dp;
    logic [1:0]  m_bright;
    int          lit_cnt, fs_cnt;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_display_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .PWM_BITS     (PB),
        .BLANK_CYCLES (BC)
    ) dut (
        .Clk_100M       (clk),
        .Reset_n        (rst_n),
        .Enable         (en),
        .Load           (load),
        .Digits         (digits),
        .Dp             (dp),
        .Brightness     (bright),
        .SegmentDrivers (seg_drv),
        .SevenSegment   (seven_seg),
        .Frame_Start    (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_disp    = '0;
        m_pend    = '0;
        m_dp      = '0;
        m_pend_dp = '0;
        m_bright  = '0;
    endtask

    // Predict the outputs for the coming edge, advance one clock, compare
    task automatic step();
        int unsigned slot, idx, pwm;
        logic        lit, e_fs;
        logic [3:0]  e_an;
        logic [7:0]  e_seg;
        slot = n % RD;
        idx  = (n / RD) % ND;
        pwm  = n % 4;
        lit  = (m_bright == 2'b11) || (pwm < 32'(m_bright));
        e_fs = (n % FRAME) == FRAME - 1;
        if (en && slot >= BC && lit) begin
            e_an  = ~(4'b0001 << idx);
            e_seg = {~m_dp[idx], seg_tab[m_disp[idx*4 +: 4]]};
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (idx > 0 && (m_disp >> (4*idx)) == 16'h0)
                e_seg[6:0] = 7'h7F;
`endif
        end else begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
        end
        if (load) begin
            m_pend    = digits;
            m_pend_dp = dp;
        end
        if (e_fs) begin
            m_disp   = m_pend;
            m_dp     = m_pend_dp;
            m_bright = bright;
        end
        @(posedge clk);
        #1;
        n++;
        check("anodes", 32'(seg_drv), 32'(e_an));
        check("segments", 32'(seven_seg), 32'(e_seg));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        if (seg_drv != 4'hF) lit_cnt++;
        if (frame_start) fs_cnt++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic align(input int unsigned phase);
        while ((n % FRAME) != phase) step();
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        digits = d;
        dp     = p;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    // Count lit clocks and frame pulses over exactly one frame with settled brightness
    task automatic frame_window(input string tag, input int exp_lit);
        step();
        align(0);
        step();
        align(0);
        lit_cnt = 0;
        fs_cnt  = 0;
        run(FRAME);
        check({tag, "_lit_clocks"}, 32'(lit_cnt), 32'(exp_lit));
        check({tag, "_frame_pulses"}, 32'(fs_cnt), 32'd1);
    endtask

    initial begin
        en     = 1'b1;
        load   = 1'b0;
        digits = '0;
        dp     = '0;
        bright = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        model_reset();
        check("reset_anodes", 32'(seg_drv), 32'hF);
        check("reset_segments", 32'(seven_seg), 32'hFF);
        check("reset_frame_start", 32'(frame_start), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Full brightness 1234: six lit clocks per slot
        bright = 2'b11;
        pulse_load(16'h1234, 4'b0000);
        frame_window("full", 24);

        // One clock in four within each lit window, then dark
        bright = 2'b01;
        frame_window("quarter", 4);
        bright = 2'b00;
        frame_window("dark", 0);
        bright = 2'b11;
        run(FRAME);

        // Mid-frame load waits for the frame boundary; frame-cycle load is immediate
        align(10);
        pulse_load(16'hABCD, 4'b0101);
        run(2 * FRAME);
        align(FRAME - 1);
        pulse_load(16'h5678, 4'b1010);
        run(FRAME + 5);

        // Enable low for three clocks mid-slot
        align(13);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(FRAME);

        pulse_load(16'h0070, 4'b1000);
        run(2 * FRAME);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                digits = 16'($urandom);
                dp     = 4'($urandom);
                load   = 1'b1;
            end
            if ($urandom_range(39, 0) == 0) bright = 2'($urandom);
            if ($urandom_range(29, 0) == 0) en = ~en;
            step();
            load = 1'b0;
        end
        en     = 1'b1;
        bright = 2'b11;
        run(FRAME);

        // Reset mid-slot discards a pending load
        align(20);
        pulse_load(16'h9999, 4'b1111);
        run(2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_anodes", 32'(seg_drv), 32'hF);
        check("midreset_segments", 32'(seven_seg), 32'hFF);
        check("midreset_frame_start", 32'(frame_start), 32'd0);
        bright = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run(2 * FRAME);
        bright = 2'b11;
        pulse_load(16'hFE01, 4'b0010);
        run(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
